// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle controller and its datapath:
// FSM states, ALU operations, mux selects and MIPS opcode/funct constants.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXEC   = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWR  = 4'd4,
    S_WB     = 4'd5,
    S_BRANCH = 4'd6,
    S_JUMP   = 4'd7,
    S_ERR    = 4'd8
  } state_e;

  localparam logic [3:0] ALU_NOP = 4'b0000;
  localparam logic [3:0] ALU_ADD = 4'b0001;
  localparam logic [3:0] ALU_SUB = 4'b0010;
  localparam logic [3:0] ALU_AND = 4'b0011;
  localparam logic [3:0] ALU_OR  = 4'b0100;
  localparam logic [3:0] ALU_SLT = 4'b0101;
  localparam logic [3:0] ALU_SLL = 4'b0110;
  localparam logic [3:0] ALU_SRL = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1000;
  localparam logic [3:0] ALU_LUI = 4'b1001;

  localparam logic [1:0] SRCA_RS    = 2'b00;
  localparam logic [1:0] SRCA_SHAMT = 2'b01;
  localparam logic [1:0] SRCA_LUI   = 2'b10;
  localparam logic [1:0] SRCB_RT    = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] NPC_PC4    = 2'b00;
  localparam logic [1:0] NPC_BR     = 2'b01;
  localparam logic [1:0] NPC_J      = 2'b10;
  localparam logic [1:0] NPC_JR     = 2'b11;
  localparam logic [1:0] GPR_RD     = 2'b00;
  localparam logic [1:0] GPR_RT     = 2'b01;
  localparam logic [1:0] GPR_RA     = 2'b10;
  localparam logic [1:0] WD_ALU     = 2'b00;
  localparam logic [1:0] WD_MEM     = 2'b01;
  localparam logic [1:0] WD_PC      = 2'b10;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;
  localparam logic [5:0] F_SLL = 6'b000000;
  localparam logic [5:0] F_SRL = 6'b000010;
  localparam logic [5:0] F_NOR = 6'b100111;
  localparam logic [5:0] F_JR  = 6'b001000;

  typedef enum logic [4:0] {
    I_ADD, I_SUB, I_AND, I_OR, I_SLT, I_SLL, I_SRL, I_NOR, I_JR,
    I_ADDI, I_ORI, I_LUI, I_LW, I_SW, I_BEQ, I_BNE, I_J, I_JAL, I_BAD
  } instr_e;

  function automatic logic [3:0] alu_op_of(instr_e i);
    case (i)
      I_ADD, I_ADDI, I_LW, I_SW: alu_op_of = ALU_ADD;
      I_SUB:                     alu_op_of = ALU_SUB;
      I_AND:                     alu_op_of = ALU_AND;
      I_OR, I_ORI:               alu_op_of = ALU_OR;
      I_SLT:                     alu_op_of = ALU_SLT;
      I_SLL:                     alu_op_of = ALU_SLL;
      I_SRL:                     alu_op_of = ALU_SRL;
      I_NOR:                     alu_op_of = ALU_NOR;
      I_LUI:                     alu_op_of = ALU_LUI;
      default:                   alu_op_of = ALU_NOP;
    endcase
  endfunction

  // R-type ALU instructions write rd; everything else that writes back uses rt.
  function automatic logic is_rtype_alu(instr_e i);
    case (i)
      I_ADD, I_SUB, I_AND, I_OR, I_SLT, I_SLL, I_SRL, I_NOR: is_rtype_alu = 1'b1;
      default:                                               is_rtype_alu = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mc_ctrl_if.sv
// Memory handshake between the controller (master) and the memory port (slave).
interface mc_ctrl_if;
  logic MemRead;
  logic MemWrite;
  logic IorD;
  logic mem_ack;

  modport master (output MemRead, MemWrite, IorD, input mem_ack);
  modport slave  (input MemRead, MemWrite, IorD, output mem_ack);
endinterface

// File: rtl/mc_ctrl_decode.sv
// Combinational instruction classifier: maps Op/Funct to an instruction id.
module mc_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  output instr_e     instr
);

  always_comb begin
    instr = I_BAD;
    case (Op)
      OP_RTYPE: begin
        case (Funct)
          F_ADD:   instr = I_ADD;
          F_SUB:   instr = I_SUB;
          F_AND:   instr = I_AND;
          F_OR:    instr = I_OR;
          F_SLT:   instr = I_SLT;
          F_SLL:   instr = I_SLL;
          F_SRL:   instr = I_SRL;
          F_NOR:   instr = I_NOR;
          F_JR:    instr = I_JR;
          default: instr = I_BAD;
        endcase
      end
      OP_ADDI: instr = I_ADDI;
      OP_ORI:  instr = I_ORI;
      OP_LUI:  instr = I_LUI;
      OP_LW:   instr = I_LW;
      OP_SW:   instr = I_SW;
      OP_BEQ:  instr = I_BEQ;
      OP_BNE:  instr = I_BNE;
      OP_J:    instr = I_J;
      OP_JAL:  instr = I_JAL;
      default: instr = I_BAD;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multicycle MIPS control FSM with a memory wait-state watchdog.
// Strobes are a function of state (plus mem_ack/Zero) and are forced low during reset.
module mc_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned STALL_LIMIT = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [5:0]      Op,
  input  logic [5:0]      Funct,
  input  logic            Zero,
  mc_ctrl_if.master       mem,
  output logic            PCWrite,
  output logic            IRWrite,
  output logic            RegWrite,
  output logic            EXTOp,
  output logic [3:0]      ALUOp,
  output logic [1:0]      ALUSrcA,
  output logic [1:0]      ALUSrcB,
  output logic [1:0]      NPCOp,
  output logic [1:0]      GPRSel,
  output logic [1:0]      WDSel,
  output logic [3:0]      state,
  output logic            err
);

  localparam int unsigned CW = $clog2(STALL_LIMIT + 1);

  state_e        cur, nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  instr_e        instr;
  logic          stall_out;
  logic          mem_rd, mem_wr, iord;

  mc_decode u_decode (.Op(Op), .Funct(Funct), .instr(instr));

  // The last permitted wait cycle; an ack on this cycle still completes the transfer.
  assign stall_out = (cnt == CW'(STALL_LIMIT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur <= S_FETCH;
      cnt <= '0;
    end else begin
      cur <= nxt;
      cnt <= cnt_nxt;
    end
  end

  // Next state; the wait counter only survives while a memory state waits on itself.
  always_comb begin
    nxt     = cur;
    cnt_nxt = '0;
    case (cur)
      S_FETCH: begin
        if (mem.mem_ack)    nxt = S_DECODE;
        else if (stall_out) nxt = S_ERR;
        else                cnt_nxt = cnt + CW'(1);
      end
      S_DECODE: begin
        case (instr)
          I_BEQ, I_BNE:      nxt = S_BRANCH;
          I_J, I_JAL, I_JR:  nxt = S_JUMP;
          I_BAD:             nxt = S_ERR;
          default:           nxt = S_EXEC;
        endcase
      end
      S_EXEC: begin
        if (instr == I_LW)      nxt = S_MEMRD;
        else if (instr == I_SW) nxt = S_MEMWR;
        else                    nxt = S_WB;
      end
      S_MEMRD: begin
        if (mem.mem_ack)    nxt = S_WB;
        else if (stall_out) nxt = S_ERR;
        else                cnt_nxt = cnt + CW'(1);
      end
      S_MEMWR: begin
        if (mem.mem_ack)    nxt = S_FETCH;
        else if (stall_out) nxt = S_ERR;
        else                cnt_nxt = cnt + CW'(1);
      end
      S_WB, S_BRANCH, S_JUMP: nxt = S_FETCH;
      S_ERR:                  nxt = S_ERR;
      default:                nxt = S_ERR;
    endcase
  end

  always_comb begin
    PCWrite  = 1'b0;
    IRWrite  = 1'b0;
    RegWrite = 1'b0;
    EXTOp    = 1'b0;
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    iord     = 1'b0;
    ALUOp    = ALU_NOP;
    ALUSrcA  = SRCA_RS;
    ALUSrcB  = SRCB_RT;
    NPCOp    = NPC_PC4;
    GPRSel   = GPR_RD;
    WDSel    = WD_ALU;
    err      = 1'b0;
    if (rst) begin
      case (cur)
        S_FETCH: begin
          mem_rd  = 1'b1;
          IRWrite = mem.mem_ack;
          PCWrite = mem.mem_ack;
        end
        S_EXEC: begin
          ALUOp   = alu_op_of(instr);
          ALUSrcA = (instr == I_SLL || instr == I_SRL) ? SRCA_SHAMT :
                    (instr == I_LUI)                   ? SRCA_LUI   : SRCA_RS;
          ALUSrcB = (instr == I_ADDI || instr == I_ORI || instr == I_LUI ||
                     instr == I_LW   || instr == I_SW) ? SRCB_IMM : SRCB_RT;
          EXTOp   = (instr != I_ORI);
        end
        S_MEMRD: begin
          iord   = 1'b1;
          mem_rd = 1'b1;
        end
        S_MEMWR: begin
          iord   = 1'b1;
          mem_wr = 1'b1;
        end
        S_WB: begin
          RegWrite = 1'b1;
          GPRSel   = is_rtype_alu(instr) ? GPR_RD : GPR_RT;
          WDSel    = (instr == I_LW) ? WD_MEM : WD_ALU;
        end
        S_BRANCH: begin
          ALUOp = ALU_SUB;
          if ((instr == I_BEQ && Zero) || (instr == I_BNE && !Zero)) begin
            PCWrite = 1'b1;
            NPCOp   = NPC_BR;
          end
        end
        S_JUMP: begin
          PCWrite = 1'b1;
          NPCOp   = (instr == I_JR) ? NPC_JR : NPC_J;
          if (instr == I_JAL) begin
            RegWrite = 1'b1;
            GPRSel   = GPR_RA;
            WDSel    = WD_PC;
          end
        end
        S_ERR:   err = 1'b1;
        default: ;
      endcase
    end
  end

  assign mem.MemRead  = mem_rd;
  assign mem.MemWrite = mem_wr;
  assign mem.IorD     = iord;
  assign state        = cur;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: per-instruction phase lists drive a cycle-by-cycle
// reference model, with literal spot checks on latency and key strobes.
module tb_mc_ctrl;

  localparam int unsigned LIMIT = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] Op;
  logic [5:0] Funct;
  logic       Zero;
  logic       PCWrite, IRWrite, RegWrite, EXTOp, err;
  logic [3:0] ALUOp, state;
  logic [1:0] ALUSrcA, ALUSrcB, NPCOp, GPRSel, WDSel;

  mc_ctrl_if mif ();

  mc_ctrl #(.STALL_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst), .Op(Op), .Funct(Funct), .Zero(Zero), .mem(mif),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .EXTOp(EXTOp),
    .ALUOp(ALUOp), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .NPCOp(NPCOp),
    .GPRSel(GPRSel), .WDSel(WDSel), .state(state), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] state;
    logic pcw, irw, rw, mw, mr, iord, ext;
    logic [3:0] aluop;
    logic [1:0] srca, srcb, npc, gsel, wdsel;
    logic err;
  } obs_t;

  obs_t obs;
  assign obs = {state, PCWrite, IRWrite, RegWrite, mif.MemWrite, mif.MemRead, mif.IorD,
                EXTOp, ALUOp, ALUSrcA, ALUSrcB, NPCOp, GPRSel, WDSel, err};

  typedef enum int {P_FETCH = 0, P_DECODE = 1, P_EXEC = 2, P_MEMRD = 3, P_MEMWR = 4,
                    P_WB = 5, P_BRANCH = 6, P_JUMP = 7, P_ERR = 8} ph_e;
  typedef struct {ph_e ph; logic ack;} step_t;
  // cls: 0 ALU op, 1 load, 2 store, 3 branch, 4 jump, 5 illegal
  typedef struct packed {
    logic [2:0] cls;
    logic [3:0] aluop;
    logic [1:0] srca, srcb;
    logic ext;
    logic [1:0] gsel, wdsel;
    logic bne, jr, jal;
  } info_t;

  int checks = 0;
  int errors = 0;
  step_t steps[$];
  int cyc_cnt, rw_cnt, pc_cnt;
  logic [15:0] st_hist;
  logic [3:0] exec_aluop;
  logic [1:0] wb_g, wb_w;
  obs_t jmp_obs;

  function automatic info_t classify(input logic [5:0] op, input logic [5:0] funct);
    info_t p;
    p = '0;
    p.ext = 1'b1;
    case (op)
      6'b000000: begin
        case (funct)
          6'b100000: p.aluop = 4'b0001;
          6'b100010: p.aluop = 4'b0010;
          6'b100100: p.aluop = 4'b0011;
          6'b100101: p.aluop = 4'b0100;
          6'b101010: p.aluop = 4'b0101;
          6'b000000: begin p.aluop = 4'b0110; p.srca = 2'b01; end
          6'b000010: begin p.aluop = 4'b0111; p.srca = 2'b01; end
          6'b100111: p.aluop = 4'b1000;
          6'b001000: begin p.cls = 3'd4; p.jr = 1'b1; end
          default:   p.cls = 3'd5;
        endcase
      end
      6'b001000: begin p.aluop = 4'b0001; p.srcb = 2'b01; p.gsel = 2'b01; end
      6'b001101: begin p.aluop = 4'b0100; p.srcb = 2'b01; p.gsel = 2'b01; p.ext = 1'b0; end
      6'b001111: begin p.aluop = 4'b1001; p.srca = 2'b10; p.srcb = 2'b01; p.gsel = 2'b01; end
      6'b100011: begin p.cls = 3'd1; p.aluop = 4'b0001; p.srcb = 2'b01; p.gsel = 2'b01; p.wdsel = 2'b01; end
      6'b101011: begin p.cls = 3'd2; p.aluop = 4'b0001; p.srcb = 2'b01; end
      6'b000100: p.cls = 3'd3;
      6'b000101: begin p.cls = 3'd3; p.bne = 1'b1; end
      6'b000010: p.cls = 3'd4;
      6'b000011: begin p.cls = 3'd4; p.jal = 1'b1; end
      default:   p.cls = 3'd5;
    endcase
    return p;
  endfunction

  function automatic obs_t expect_out(input ph_e ph, input info_t p, input logic ack, input logic z);
    obs_t o;
    o = '0;
    o.state = 4'(ph);
    case (ph)
      P_FETCH:  begin o.mr = 1'b1; o.irw = ack; o.pcw = ack; end
      P_EXEC:   begin o.aluop = p.aluop; o.srca = p.srca; o.srcb = p.srcb; o.ext = p.ext; end
      P_MEMRD:  begin o.iord = 1'b1; o.mr = 1'b1; end
      P_MEMWR:  begin o.iord = 1'b1; o.mw = 1'b1; end
      P_WB:     begin o.rw = 1'b1; o.gsel = p.gsel; o.wdsel = p.wdsel; end
      P_BRANCH: begin
        o.aluop = 4'b0010;
        if (p.bne ? !z : z) begin o.pcw = 1'b1; o.npc = 2'b01; end
      end
      P_JUMP: begin
        o.pcw = 1'b1;
        o.npc = p.jr ? 2'b11 : 2'b10;
        if (p.jal) begin o.rw = 1'b1; o.gsel = 2'b10; o.wdsel = 2'b10; end
      end
      P_ERR:   o.err = 1'b1;
      default: ;
    endcase
    return o;
  endfunction

  function automatic void push(input ph_e ph, input logic ack);
    step_t s;
    s.ph = ph;
    s.ack = ack;
    steps.push_back(s);
  endfunction

  // Memory phase waiting w cycles before ack; returns 1 if the watchdog fires.
  function automatic bit push_wait(input ph_e ph, input int w, input logic noise);
    if (w >= int'(LIMIT)) begin
      repeat (LIMIT) push(ph, 1'b0);
      repeat (3) push(P_ERR, noise);
      return 1'b1;
    end
    repeat (w) push(ph, 1'b0);
    push(ph, 1'b1);
    return 1'b0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic compare_cycle(input string name, input obs_t e);
    checks++;
    cyc_cnt++;
    if (obs !== e) begin
      errors++;
      $display("FAIL %s cycle %0d: state %0d (expected %0d) outputs %h (expected %h)",
               name, cyc_cnt, obs.state, e.state, obs, e);
    end
    st_hist = {st_hist[11:0], obs.state};
    if (obs.rw)  rw_cnt++;
    if (obs.pcw) pc_cnt++;
    if (obs.state == 4'd2) exec_aluop = obs.aluop;
    if (obs.state == 4'd5) begin wb_g = obs.gsel; wb_w = obs.wdsel; end
    if (obs.state == 4'd7) jmp_obs = obs;
  endtask

  task automatic run(input string name, input logic [5:0] op, input logic [5:0] funct,
                     input logic z, input int fw, input int mw, input logic noise,
                     input bit rst_mid);
    info_t p;
    obs_t e;
    bit died;
    p = classify(op, funct);
    steps.delete();
    cyc_cnt = 0; rw_cnt = 0; pc_cnt = 0; st_hist = '0;
    died = push_wait(P_FETCH, fw, noise);
    if (!died) begin
      push(P_DECODE, noise);
      case (p.cls)
        3'd0: begin push(P_EXEC, noise); push(P_WB, noise); end
        3'd1: begin
          push(P_EXEC, noise);
          if (!push_wait(P_MEMRD, mw, noise)) push(P_WB, noise);
        end
        3'd2: begin push(P_EXEC, noise); died = push_wait(P_MEMWR, mw, noise); end
        3'd3: push(P_BRANCH, noise);
        3'd4: push(P_JUMP, noise);
        default: repeat (3) push(P_ERR, noise);
      endcase
    end
    Op = op; Funct = funct; Zero = z;
    for (int i = 0; i < steps.size(); i++) begin
      mif.mem_ack = steps[i].ack;
      e = expect_out(steps[i].ph, p, steps[i].ack, z);
      if (rst_mid && steps[i].ph == P_MEMWR) begin
        #1;
        check({name, "_memwr_before_rst"}, 32'(mif.MemWrite), 32'd1);
        rst = 1'b0;
        #1;
        check({name, "_memwr_async_drop"}, 32'(mif.MemWrite), 32'd0);
        check({name, "_state_async_rst"}, 32'(state), 32'd0);
        return;
      end
      @(negedge clk);
      compare_cycle(name, e);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input string name);
    mif.mem_ack = 1'b0;
    rst = 1'b0;
    #2;
    check({name, "_state"}, 32'(state), 32'd0);
    check({name, "_err"}, 32'(err), 32'd0);
    check({name, "_memread"}, 32'(mif.MemRead), 32'd0);
    check({name, "_pcwrite"}, 32'(PCWrite), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b1; Op = '0; Funct = '0; Zero = 1'b0; mif.mem_ack = 1'b0;
    #1;
    do_reset("reset");

    run("add", 6'b000000, 6'b100000, 1'b0, 0, 0, 1'b0, 1'b0);
    check("add_states", 32'(st_hist), 32'h0125);
    check("add_aluop", 32'(exec_aluop), 32'h1);
    check("add_regwrite_pulses", 32'(rw_cnt), 32'd1);
    check("add_gprsel", 32'(wb_g), 32'd0);
    run("sub", 6'b000000, 6'b100010, 1'b0, 2, 0, 1'b1, 1'b0);
    run("and", 6'b000000, 6'b100100, 1'b0, 1, 0, 1'b0, 1'b0);
    run("or",  6'b000000, 6'b100101, 1'b0, 0, 0, 1'b1, 1'b0);
    run("slt", 6'b000000, 6'b101010, 1'b0, 0, 0, 1'b0, 1'b0);
    run("sll", 6'b000000, 6'b000000, 1'b0, 3, 0, 1'b0, 1'b0);
    run("srl", 6'b000000, 6'b000010, 1'b0, 0, 0, 1'b1, 1'b0);
    run("nor", 6'b000000, 6'b100111, 1'b0, 0, 0, 1'b1, 1'b0);
    run("addi", 6'b001000, 6'b101010, 1'b0, 0, 0, 1'b0, 1'b0);
    run("ori",  6'b001101, 6'b101010, 1'b0, 1, 0, 1'b0, 1'b0);
    run("lui",  6'b001111, 6'b101010, 1'b0, 0, 0, 1'b1, 1'b0);
    run("sw",   6'b101011, 6'b000000, 1'b0, 0, 0, 1'b0, 1'b0);
    check("sw_cycles", 32'(cyc_cnt), 32'd4);
    run("sw_wait", 6'b101011, 6'b000000, 1'b0, 0, 2, 1'b1, 1'b0);
    run("lw", 6'b100011, 6'b000000, 1'b0, 3, 3, 1'b0, 1'b0);
    check("lw_cycles", 32'(cyc_cnt), 32'd11);
    check("lw_wdsel", 32'(wb_w), 32'd1);
    check("lw_gprsel", 32'(wb_g), 32'd1);
    run("lw_edge", 6'b100011, 6'b000000, 1'b0, 0, 15, 1'b1, 1'b0);
    run("beq_t", 6'b000100, 6'b000000, 1'b1, 0, 0, 1'b0, 1'b0);
    check("beq_t_pcwrites", 32'(pc_cnt), 32'd2);
    check("beq_t_cycles", 32'(cyc_cnt), 32'd3);
    run("beq_nt", 6'b000100, 6'b000000, 1'b0, 0, 0, 1'b0, 1'b0);
    check("beq_nt_pcwrites", 32'(pc_cnt), 32'd1);
    run("bne_t",  6'b000101, 6'b000000, 1'b0, 0, 0, 1'b1, 1'b0);
    run("bne_nt", 6'b000101, 6'b000000, 1'b1, 0, 0, 1'b0, 1'b0);
    run("j",   6'b000010, 6'b000000, 1'b0, 0, 0, 1'b0, 1'b0);
    check("j_cycles", 32'(cyc_cnt), 32'd3);
    run("jal", 6'b000011, 6'b000000, 1'b0, 0, 0, 1'b0, 1'b0);
    check("jal_jump_strobes", 32'({jmp_obs.pcw, jmp_obs.npc, jmp_obs.rw, jmp_obs.gsel, jmp_obs.wdsel}),
          32'b1_10_1_10_10);
    run("jr",  6'b000000, 6'b001000, 1'b0, 1, 0, 1'b1, 1'b0);
    run("fetch_edge", 6'b000000, 6'b100000, 1'b0, 15, 0, 1'b0, 1'b0);

    run("fetch_stall", 6'b000000, 6'b100000, 1'b0, 16, 0, 1'b0, 1'b0);
    check("stall_state", 32'(state), 32'd8);
    check("stall_err", 32'(err), 32'd1);
    do_reset("stall_rst");
    run("memrd_stall", 6'b100011, 6'b000000, 1'b0, 0, 16, 1'b0, 1'b0);
    check("memrd_stall_err", 32'(err), 32'd1);
    do_reset("memrd_rst");
    run("bad_op", 6'b111111, 6'b000000, 1'b0, 0, 0, 1'b0, 1'b0);
    check("bad_op_state", 32'(state), 32'd8);
    do_reset("bad_op_rst");
    run("bad_funct", 6'b000000, 6'b111111, 1'b0, 0, 0, 1'b1, 1'b0);
    do_reset("bad_funct_rst");
    run("sw_rst", 6'b101011, 6'b000000, 1'b0, 0, 5, 1'b0, 1'b1);
    do_reset("sw_rst_rel");
    run("fresh_count", 6'b000000, 6'b100101, 1'b0, 15, 0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mc_ctrl.md
MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 SHALL have parameter STALL_LIMIT, default 16: maximum cycles to wait for mem_ack before declaring an error.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates occur on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset (rst=0 resets).
REQ-004 SHALL have port Op  input  6  instr[31:26] from the instruction register.
REQ-005 SHALL have port Funct  input  6  instr[5:0] from the instruction register.
REQ-006 SHALL have port Zero  input  1  ALU zero flag.
REQ-007 SHALL have port mem_ack  input  1  memory transfer complete, valid while MemRead or MemWrite is high.
REQ-008 SHALL have outputs PCWrite, IRWrite, RegWrite, MemWrite, MemRead, IorD, EXTOp, each 1 bit, with their usual datapath strobe/select meaning (IorD=1: memory address from ALU output).
REQ-009 SHALL have outputs ALUOp 4, ALUSrcA 2, ALUSrcB 2, NPCOp 2, GPRSel 2, WDSel 2: datapath selects.
REQ-010 SHALL have outputs state 4 (current FSM state, for debug) and err 1 (sticky fault).

Function
REQ-011 SHALL implement the Moore FSM FETCH=0, DECODE=1, EXEC=2, MEMRD=3, MEMWR=4, WB=5, BRANCH=6, JUMP=7, ERR=8.
REQ-012 FETCH SHALL drive MemRead=1, IorD=0, and hold until mem_ack; on mem_ack it SHALL pulse IRWrite=1 and PCWrite=1 with NPCOp=00 (PC+4), then go to DECODE.
REQ-013 DECODE SHALL route by Op: R-type (000000), addi, ori, lw, sw and lui to EXEC; beq/bne to BRANCH; j/jal to JUMP; R-type Funct jr (001000) to JUMP; any other Op/Funct to ERR.
REQ-014 EXEC SHALL set ALUOp per instruction (ADD=0001, SUB=0010, AND=0011, OR=0100, SLT=0101, SLL=0110, SRL=0111, NOR=1000, LUI=1001).
REQ-015 EXEC SHALL set ALUSrcA to 01 for sll/srl (shamt), 10 for lui, and 00 otherwise.
REQ-016 EXEC SHALL set ALUSrcB to 01 (Imm32) for immediate instructions, lw and sw, and 00 (rt) otherwise.
REQ-017 EXEC SHALL set EXTOp=1 (sign extend) except for ori (EXTOp=0).
REQ-018 EXEC SHALL go next to MEMRD for lw, to MEMWR for sw, and to WB otherwise.
REQ-019 MEMRD and MEMWR SHALL drive IorD=1 with MemRead=1 or MemWrite=1 respectively, held until mem_ack; on ack MEMRD goes to WB and MEMWR goes to FETCH.
REQ-020 WB SHALL pulse RegWrite=1 for one cycle, then go to FETCH.
REQ-021 WB write-select: GPRSel=00 (rd) for R-type, 01 (rt) for I-type; WDSel=01 (memory) for lw, 00 (ALU) otherwise.
REQ-022 BRANCH SHALL set ALUOp=SUB and ALUSrcB=00, and SHALL assert PCWrite with NPCOp=01 iff (beq and Zero) or (bne and not Zero); it then goes to FETCH.
REQ-023 JUMP SHALL assert PCWrite with NPCOp=10 for j/jal and NPCOp=11 for jr, then go to FETCH.
REQ-024 For jal, JUMP SHALL additionally assert RegWrite=1 with GPRSel=10 ($31) and WDSel=10 (the PC value, already PC+4).
REQ-025 A wait counter SHALL clear on entry to FETCH, MEMRD or MEMWR and increment each cycle without mem_ack; reaching STALL_LIMIT SHALL go to ERR.
REQ-026 mem_ack arriving on the same cycle as the counter reaching the limit SHALL win: the transfer completes and the FSM does not go to ERR.
REQ-027 ERR SHALL hold err=1 with all strobes at 0 until reset.
REQ-028 All strobes not listed for a state SHALL be 0, and all selects SHALL be 0 by default.
REQ-029 mem_ack outside a memory state SHALL be ignored.
REQ-030 Per-instruction latency with zero wait states SHALL be: R-type/immediate 4 cycles, lw 5, sw 4, branch 3, jump 3.

Reset
REQ-031 rst=0 SHALL immediately force state=FETCH, clear the wait counter, set err=0 and set every output strobe to 0, including in the middle of a transfer.
REQ-032 The first FETCH after rst rises SHALL start a fresh wait count.

Structure
REQ-033 State encodings, ALUOp codes, NPCOp/GPRSel/WDSel/ALUSrc codes and opcode/funct constants SHALL reside in a shared package used by mc_ctrl and the datapath.
REQ-034 Instruction decode (Op/Funct to instruction class) SHALL be a combinational sub-module named mc_decode; the FSM and counter remain in mc_ctrl.

Verification
REQ-035 add $3,$1,$2 (Op 000000, Funct 100000) with mem_ack on the first cycle -> states 0,1,2,5; ALUOp=0001; RegWrite pulsed once with GPRSel=00.
REQ-036 lw with mem_ack delayed 3 cycles in both FETCH and MEMRD -> 11 cycles total; WB has WDSel=01, GPRSel=01.
REQ-037 beq with Zero=1 then Zero=0 -> PCWrite in BRANCH only for the first, NPCOp=01.
REQ-038 jal -> JUMP asserts PCWrite, NPCOp=10, RegWrite, GPRSel=10, WDSel=10 in one cycle.
REQ-039 mem_ack withheld 16 cycles in FETCH -> state=8, err=1 held; rst=0 -> state=0, err=0.
REQ-040 Op=111111 -> ERR after DECODE; rst asserted mid-MEMWR -> MemWrite drops asynchronously.
